// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, frame edge numbering
// and the odd-parity helper used by both the transmit and receive paths.
package ps2_pkg;

   // Host transmit FSM state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_RTS       = 3'd2;
   localparam logic [2:0] ST_XFER      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

   // Frame layout, counted in device-generated falling clock edges
   localparam int DATA_BITS   = 8;
   localparam int PARITY_EDGE = 9;
   localparam int STOP_EDGE   = 10;
   localparam int ACK_EDGE    = 11;

   // Odd parity: the bit that makes the total count of ones odd
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizer plus falling-edge detector for one PS/2 line.
// The chain resets to 1 (bus idle level) so leaving reset never looks
// like a falling edge. SYNC_STAGES must be at least 1.
module ps2_line_sync
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_sync,
   output logic fall
);

   logic [SYNC_STAGES-1:0] stage_q;
   logic [SYNC_STAGES-1:0] stage_d;
   logic                   prev_q;
   logic                   prev_d;

   // Each stage takes the previous stage; stage 0 takes the raw pin
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_d[gi] = line_in;
         end else begin : g_next
            assign stage_d[gi] = stage_q[gi-1];
         end
      end
   endgenerate

   assign line_sync = stage_q[SYNC_STAGES-1];

   // Remember last synced level for edge detection
   always_comb begin
      prev_d = line_sync;
   end

   // Synchronizer chain and edge history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '1;
         prev_q  <= 1'b1;
      end else begin
         stage_q <= stage_d;
         prev_q  <= prev_d;
      end
   end

   assign fall = prev_q & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send,
// then shifts start/data/parity/stop on device clock falls and checks the ACK.
// All outputs are registered; reset clears them asynchronously so the pins
// are released the instant rst rises.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             clk_sync;
   logic             clk_fall;
   logic             data_sync;
   logic             data_fall_unused;

   logic [2:0]       state_q,    state_d;
   logic [7:0]       data_q,     data_d;
   logic             par_q,      par_d;
   logic [INH_W-1:0] inh_cnt_q,  inh_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
   logic [3:0]       edge_cnt_q, edge_cnt_d;
   logic             ack_ok_q,   ack_ok_d;
   logic             clk_oe_q,   clk_oe_d;
   logic             data_oe_q,  data_oe_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   logic             err_q,      err_d;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clk       (clk),
      .rst       (rst),
      .line_in   (ps2_clk_in),
      .line_sync (clk_sync),
      .fall      (clk_fall)
   );

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
      .clk       (clk),
      .rst       (rst),
      .line_in   (ps2_data_in),
      .line_sync (data_sync),
      .fall      (data_fall_unused)
   );

   // Next-state and next-output logic for the transmit sequence
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      par_d      = par_q;
      inh_cnt_d  = inh_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      edge_cnt_d = edge_cnt_q;
      ack_ok_d   = ack_ok_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            // A completion pulse cycle is still the tail of the old frame
            if (tx_start && !done_q && !err_q) begin
               data_d    = tx_data;
               par_d     = odd_parity(tx_data);
               inh_cnt_d = '0;
               state_d   = ST_INHIBIT;
               busy_d    = 1'b1;
               clk_oe_d  = 1'b1;
            end
         end

         ST_INHIBIT: begin
            if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
               inh_cnt_d = '0;
               state_d   = ST_RTS;
               data_oe_d = 1'b1;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end

         ST_RTS: begin
            // Release clock, keep start bit on data
            state_d    = ST_XFER;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b1;
            tmo_cnt_d  = '0;
            edge_cnt_d = '0;
         end

         ST_XFER: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (clk_fall && edge_cnt_q == 4'(ACK_EDGE - 1)) begin
               // Device holds data low on the ACK edge when it accepted the frame
               ack_ok_d   = ~data_sync;
               data_oe_d  = 1'b0;
               edge_cnt_d = '0;
               tmo_cnt_d  = '0;
               state_d    = ST_WAIT_IDLE;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               // Device stopped clocking: abort without waiting for idle lines
               clk_oe_d   = 1'b0;
               data_oe_d  = 1'b0;
               busy_d     = 1'b0;
               err_d      = 1'b1;
               edge_cnt_d = '0;
               tmo_cnt_d  = '0;
               state_d    = ST_IDLE;
            end else if (clk_fall) begin
               edge_cnt_d = edge_cnt_q + 4'd1;
               if (edge_cnt_q < 4'(DATA_BITS)) begin
                  data_oe_d = ~data_q[edge_cnt_q[2:0]];
               end else if (edge_cnt_q == 4'(PARITY_EDGE - 1)) begin
                  data_oe_d = ~par_q;
               end else begin
                  data_oe_d = 1'b0;
               end
            end
         end

         ST_WAIT_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (clk_sync && data_sync) begin
               done_d  = ack_ok_q;
               err_d   = ~ack_ok_q;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         par_q      <= 1'b0;
         inh_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         edge_cnt_q <= '0;
         ack_ok_q   <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         par_q      <= par_d;
         inh_cnt_q  <= inh_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ack_ok_q   <= ack_ok_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign busy        = busy_q;
   assign tx_done     = done_q;
   assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model on open-collector lines,
// an expectation queue filled at request time, and a monitor that checks
// each completion pulse against the queue and the frame the device saw.
module tb_ps2_host_tx;

   localparam int INH  = 200;
   localparam int TMO  = 3000;
   localparam int HALF = 20;

   localparam int K_ACK  = 0;
   localparam int K_NACK = 1;
   localparam int K_TMO  = 2;
   localparam int K_RST  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
   wire        ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   wire        ps2_data_line = ~(ps2_data_oe | dev_data_low);

   typedef struct { logic [7:0] b; logic par; int kind; } exp_t;
   typedef struct { logic [7:0] b; logic par; logic stop; } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_pulses = 0;
   int   n_expected = 0;
   int   txn_id = 0;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .busy        (busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference parity: the bit that makes the count of ones odd
   function automatic logic ref_parity(input logic [7:0] b);
      return ($countones(b) % 2) == 0;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compares every completion pulse with the queued expectation
   always @(negedge clk) begin : mon
      exp_t        e;
      obs_t        o;
      logic [31:0] want;
      if (!rst && (tx_done || tx_err)) begin
         n_pulses++;
         check("done_err_exclusive", 32'(tx_done & tx_err), 32'(0));
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'({tx_done, tx_err}), 32'(0));
         end else begin
            e = exp_q.pop_front();
            want = (e.kind == K_ACK) ? 32'h2 : 32'h1;
            check("outcome", 32'({tx_done, tx_err}), want);
            check("busy_at_end", 32'(busy), 32'(0));
            check("oe_at_end", 32'({ps2_clk_oe, ps2_data_oe}), 32'(0));
            if (e.kind != K_TMO) begin
               if (obs_q.size() == 0) begin
                  check("frame_seen", 32'(0), 32'(1));
               end else begin
                  o = obs_q.pop_front();
                  check("rx_byte", 32'(o.b), 32'(e.b));
                  check("rx_parity", 32'(o.par), 32'(e.par));
                  check("rx_stop", 32'(o.stop), 32'(1));
                  $display("txn %0d: byte %02h kind %0d -> device got %02h par %0b, done=%0b err=%0b",
                           txn_id, e.b, e.kind, o.b, o.par, tx_done, tx_err);
               end
            end else begin
               $display("txn %0d: byte %02h timeout -> done=%0b err=%0b", txn_id, e.b, tx_done, tx_err);
            end
         end
      end
   end

   // Device model: checks the request-to-send timing, then clocks the frame
   task automatic device(input int kind, input bit inject, input logic [7:0] inj_byte);
      int         n;
      logic [9:0] bits;
      logic       d;
      bits = '0;
      @(negedge clk);
      n = 0;
      while (!ps2_clk_oe && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("inhibit_seen", 32'(ps2_clk_oe), 32'(1));
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < INH + 50) begin
         n++;
         @(negedge clk);
      end
      check("inhibit_len", 32'(n), 32'(INH));
      n = 0;
      while (ps2_clk_oe && ps2_data_oe && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("rts_len", 32'(n), 32'(1));
      check("start_bit", 32'({ps2_clk_oe, ps2_data_line}), 32'(0));
      if (kind == K_TMO) begin
         n = 0;
         while (!tx_err && n < TMO + 50) begin
            @(negedge clk);
            n++;
         end
         check("timeout_len", 32'(n), 32'(TMO));
         wait_cyc(1);
         return;
      end
      wait_cyc(10);
      for (int i = 1; i <= 11; i++) begin
         if (i == 11 && kind == K_ACK) begin
            dev_data_low = 1'b1;
            wait_cyc(HALF / 2);
         end
         dev_clk_low = 1'b1;
         if (kind == K_RST && i == 5) begin
            wait_cyc(8);
            #2 rst = 1'b1;
            #1 check("rst_release", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'(0));
            dev_clk_low = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            return;
         end
         wait_cyc(HALF);
         d = ps2_data_line;
         dev_clk_low = 1'b0;
         if (i <= 10) bits[i-1] = d;
         if (i == 10) obs_q.push_back('{bits[7:0], bits[8], bits[9]});
         if (i == 11) dev_data_low = 1'b0;
         wait_cyc(HALF);
         if (i <= 10) check("data_hold", 32'(ps2_data_line), 32'(d));
         if (inject && i == 3) begin
            tx_data  = inj_byte;
            tx_start = 1'b1;
            wait_cyc(1);
            tx_start = 1'b0;
         end
      end
   endtask

   // One request: queue expectation, pulse tx_start, run the device
   task automatic send(input logic [7:0] b, input int kind, input bit inject);
      exp_t e;
      int   n;
      txn_id++;
      if (kind != K_RST) begin
         e.b    = b;
         e.par  = ref_parity(b);
         e.kind = kind;
         exp_q.push_back(e);
         n_expected++;
      end
      tx_data  = b;
      tx_start = 1'b1;
      wait_cyc(1);
      tx_start = 1'b0;
      tx_data  = 8'($urandom);
      device(kind, inject, 8'hAA);
      n = 0;
      while (busy && n < 2000) begin
         wait_cyc(1);
         n++;
      end
      check("busy_drop", 32'(busy), 32'(0));
      wait_cyc(5);
      check("stay_idle", 32'({busy, ps2_clk_oe, ps2_data_oe}), 32'(0));
      check("pulse_count", 32'(n_pulses), 32'(n_expected));
      if (kind == K_RST) $display("txn %0d: byte %02h reset mid-frame -> no pulse", txn_id, b);
   endtask

   initial begin
      logic [7:0] rb;
      int         rk;
      wait_cyc(3);
      check("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err}), 32'(0));
      rst = 1'b0;
      wait_cyc(5);
      check("idle_after_reset", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'(0));

      send(8'hED, K_ACK, 1'b0);
      send(8'h07, K_ACK, 1'b0);
      send(8'h00, K_ACK, 1'b0);
      send(8'hFF, K_ACK, 1'b0);
      send(8'h55, K_NACK, 1'b0);
      send(8'h3C, K_TMO, 1'b0);
      send(8'hF4, K_ACK, 1'b1);
      send(8'hED, K_RST, 1'b0);
      send(8'hED, K_ACK, 1'b0);
      for (int t = 0; t < 8; t++) begin
         rb = 8'($urandom);
         rk = ($urandom_range(0, 3) == 0) ? K_NACK : K_ACK;
         send(rb, rk, 1'b0);
      end

      check("queue_empty", 32'(exp_q.size()), 32'(0));
      check("total_pulses", 32'(n_pulses), 32'(n_expected));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
